// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/flush; FETCH_MISALIGN_CHECK_EN traps misaligned targets.
// Latency: request issued the cycle after acceptance of the previous instruction; 3 cycles/instr with 1-cycle memory.
// Backpressure: holds if_* stable while if_ready=0; stalls in REQ while imem_req_ready=0.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc_out
`ifdef FETCH_MISALIGN_CHECK_EN
  ,output logic       fetch_misalign
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] req_pc;
  logic        redir;
  logic [31:0] raw_target;
  logic [31:0] redir_target;

  always_comb begin
    redir      = trap_req | jump | branch_taken;
    raw_target = trap_req ? TRAP_VECTOR : (jump ? jump_target : branch_target);
`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_misalign = rst && redir && (raw_target[1:0] != 2'b00);
    redir_target   = fetch_misalign ? TRAP_VECTOR : raw_target;
`else
    redir_target   = raw_target & 32'hFFFF_FFFC;
`endif
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) state_nxt = redir ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redir)                state_nxt = imem_resp_valid ? REQ : DRAIN;
        else if (imem_resp_valid) state_nxt = HOLD;
      end
      HOLD: begin
        if (redir || (if_valid && if_ready)) state_nxt = REQ;
      end
      // A redirect here only moves pc_out; the in-flight response must still be absorbed.
      DRAIN: begin
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc_out   <= RESET_VECTOR;
      req_pc   <= 32'h0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else begin
      state <= state_nxt;

      if (redir)
        pc_out <= redir_target;
      else if (state == REQ && imem_req_ready)
        pc_out <= pc_out + 32'd4;

      if (state == REQ && imem_req_ready)
        req_pc <= pc_out;

      if (redir) begin
        if_valid <= 1'b0;
      end else if (state == WAIT && imem_resp_valid) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_resp_data;
      end else if (state == HOLD && if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory model returns addr ^ 32'hDEAD_0000 after mem_delay cycles.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, jump, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        if_ready;
  logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_delay = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .pc_out         (pc_out)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,.fetch_misalign(fetch_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample request handshake mid-cycle, advance, then update the memory model.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      cnt   = mem_delay;
      paddr = a;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = paddr ^ 32'hDEAD_0000;
        pend            = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; trap_req = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    if_ready = 1'b1;

    step(); step();
    check("rst_pc", pc_out, 32'h0);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);

    // Release: one IDLE cycle, then sequential fetch 0x0, 0x4, 0x8
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check("seq_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("seq_req_addr", imem_req_addr, 32'(4 * k));
      step();
      step();
      check("seq_if_valid", {31'h0, if_valid}, 32'h1);
      check("seq_if_pc", if_pc, 32'(4 * k));
      check("seq_if_instr", if_instr, 32'hDEAD_0000 | 32'(4 * k));
      step();
    end

    // Decode stall in HOLD
    if_ready = 1'b0;
    check("stall_req_addr", imem_req_addr, 32'hC);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_if_valid", {31'h0, if_valid}, 32'h1);
      check("stall_if_pc", if_pc, 32'hC);
      check("stall_if_instr", if_instr, 32'hDEAD_000C);
      check("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    if_ready = 1'b1;
    step();
    check("unstall_req_addr", imem_req_addr, 32'h10);

    // Simultaneous redirects in REQ with memory not ready: trap wins, request re-issued
    imem_req_ready = 1'b0;
    trap_req = 1'b1; jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    step();
    trap_req = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check("prio_pc", pc_out, 32'h100);
    check("prio_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("prio_req_addr", imem_req_addr, 32'h100);

    // Jump in WAIT, response 3 cycles after the jump cycle
    imem_req_ready = 1'b1;
    mem_delay = 4;
    step();
    jump = 1'b1; jump_target = 32'h80;
    step();
    jump = 1'b0;
    check("drain_pc", pc_out, 32'h80);
    check("drain_req_valid", {31'h0, imem_req_valid}, 32'h0);
    step();
    check("drain_req_valid2", {31'h0, imem_req_valid}, 32'h0);
    step();
    check("drain_if_valid", {31'h0, if_valid}, 32'h0);
    step();
    check("drain_if_valid2", {31'h0, if_valid}, 32'h0);
    check("drain_req_valid3", {31'h0, imem_req_valid}, 32'h1);
    check("drain_req_addr", imem_req_addr, 32'h80);
    mem_delay = 1;

    // Jump to top of address space (accepted in REQ -> DRAIN), then wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    step();
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc_out, 32'h0);
    step();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_if_instr", if_instr, 32'h2152_FFFC);
    step();
    check("wrap_next_addr", imem_req_addr, 32'h0);

    // Misaligned branch in HOLD with if_ready=1: flush wins
    step(); step();
    check("flush_pre_valid", {31'h0, if_valid}, 32'h1);
    branch_taken = 1'b1; branch_target = 32'h202;
`ifdef FETCH_MISALIGN_CHECK_EN
    #1;
    check("misalign_pulse", {31'h0, fetch_misalign}, 32'h1);
`endif
    step();
    branch_taken = 1'b0;
    check("flush_if_valid", {31'h0, if_valid}, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_pc", pc_out, 32'h100);
    check("misalign_clear", {31'h0, fetch_misalign}, 32'h0);
`else
    check("align_pc", pc_out, 32'h200);
`endif

    // Reset mid-request outranks a redirect; late response is dropped
    step();
    rst = 1'b0; jump = 1'b1; jump_target = 32'h400;
    step();
    jump = 1'b0;
    check("mrst_pc", pc_out, 32'h0);
    check("mrst_if_valid", {31'h0, if_valid}, 32'h0);
    check("mrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    rst = 1'b1;
    step();
    check("mrst_if_valid2", {31'h0, if_valid}, 32'h0);
    check("mrst_req_addr", imem_req_addr, 32'h0);
    step();
    check("mrst_if_valid3", {31'h0, if_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
